axis_width_downsizer: RTL and testbench



---
 rtl/axis_pkg.sv | 35 +++
 rtl/axis_width_downsizer.sv | 147 ++++++++++++++
 tb/tb_axis_width_downsizer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream width-converter helpers: state encoding, index sizing and
// the input/output width legality rule.
package axis_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SPLIT = 1'b1
  } dsz_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Slice index must stay at least one bit wide even when RATIO==1.
  function automatic int idx_width(input int ratio);
    int w;
    w = clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit ratio_legal(input int s_bytes, input int m_bytes);
    if (m_bytes < 1 || m_bytes > 256) return 1'b0;
    if (s_bytes < 2 || s_bytes > 512) return 1'b0;
    if (s_bytes < m_bytes) return 1'b0;
    return (s_bytes % m_bytes) == 0;
  endfunction

endpackage

// File: rtl/axis_width_downsizer.sv
// Wide-to-narrow AXI4-Stream converter: holds one wide beat and emits it as
// narrow slices, LSB slice first, dropping trailing null slices of tlast beats.
module axis_width_downsizer
  import axis_pkg::*;
#(
  parameter int S_TDATA_WIDTH        = 8,
  parameter int M_TDATA_WIDTH        = 2,
  parameter int TID_WIDTH            = 1,
  parameter int TDEST_WIDTH          = 1,
  parameter int TUSER_WIDTH_PER_BYTE = 1
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,
  input  logic                                          s_axis_tvalid,
  output logic                                          s_axis_tready,
  input  logic [S_TDATA_WIDTH*8-1:0]                    s_axis_tdata,
  input  logic [S_TDATA_WIDTH-1:0]                      s_axis_tstrb,
  input  logic [S_TDATA_WIDTH-1:0]                      s_axis_tkeep,
  input  logic                                          s_axis_tlast,
  input  logic [TID_WIDTH-1:0]                          s_axis_tid,
  input  logic [TDEST_WIDTH-1:0]                        s_axis_tdest,
  input  logic [S_TDATA_WIDTH*TUSER_WIDTH_PER_BYTE-1:0] s_axis_tuser,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic [M_TDATA_WIDTH*8-1:0]                    m_axis_tdata,
  output logic [M_TDATA_WIDTH-1:0]                      m_axis_tstrb,
  output logic [M_TDATA_WIDTH-1:0]                      m_axis_tkeep,
  output logic [M_TDATA_WIDTH*TUSER_WIDTH_PER_BYTE-1:0] m_axis_tuser,
  output logic                                          m_axis_tlast,
  output logic [TID_WIDTH-1:0]                          m_axis_tid,
  output logic [TDEST_WIDTH-1:0]                        m_axis_tdest
);

  localparam int RATIO = S_TDATA_WIDTH / M_TDATA_WIDTH;
  localparam int IDX_W = idx_width(RATIO);
  localparam int SD_W  = S_TDATA_WIDTH * BYTE_W;
  localparam int MD_W  = M_TDATA_WIDTH * BYTE_W;
  localparam int SU_W  = S_TDATA_WIDTH * TUSER_WIDTH_PER_BYTE;
  localparam int MU_W  = M_TDATA_WIDTH * TUSER_WIDTH_PER_BYTE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (!ratio_legal(S_TDATA_WIDTH, M_TDATA_WIDTH)) begin : g_bad_ratio
    $error("axis_width_downsizer: S_TDATA_WIDTH must be a multiple of M_TDATA_WIDTH");
  end

  dsz_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   en_q, en_d;
  logic [SD_W-1:0]        data_q, data_d;
  logic [S_TDATA_WIDTH-1:0] strb_q, strb_d;
  logic [S_TDATA_WIDTH-1:0] keep_q, keep_d;
  logic [SU_W-1:0]        user_q, user_d;
  logic                   last_q, last_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;

  logic                     final_slice;
  logic [S_TDATA_WIDTH-1:0] upper_keep;
  logic                     s_hs;
  logic                     m_hs;

  // A slice is the last one emitted when nothing kept lies above it in a tlast beat.
  always_comb begin
    upper_keep  = keep_q >> ((int'(idx_q) + 1) * M_TDATA_WIDTH);
    final_slice = (idx_q == LAST_IDX) || (last_q && (upper_keep == '0));
  end

  // en_q holds s_axis_tready low until the first edge after reset release.
  assign s_axis_tready = en_q && ((state_q == ST_EMPTY) || (m_axis_tready && final_slice));
  assign m_axis_tvalid = (state_q == ST_SPLIT);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = m_axis_tvalid && m_axis_tready;

  assign m_axis_tdata  = data_q[int'(idx_q) * MD_W +: MD_W];
  assign m_axis_tstrb  = strb_q[int'(idx_q) * M_TDATA_WIDTH +: M_TDATA_WIDTH];
  assign m_axis_tkeep  = keep_q[int'(idx_q) * M_TDATA_WIDTH +: M_TDATA_WIDTH];
  assign m_axis_tuser  = user_q[int'(idx_q) * MU_W +: MU_W];
  assign m_axis_tlast  = (state_q == ST_SPLIT) && last_q && final_slice;
  assign m_axis_tid    = tid_q;
  assign m_axis_tdest  = tdest_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = 1'b1;
    data_d  = data_q;
    strb_d  = strb_q;
    keep_d  = keep_q;
    user_d  = user_q;
    last_d  = last_q;
    tid_d   = tid_q;
    tdest_d = tdest_q;

    case (state_q)
      ST_EMPTY: begin
        if (s_hs) state_d = ST_SPLIT;
      end
      ST_SPLIT: begin
        if (m_hs) begin
          if (!final_slice) idx_d = idx_q + 1'b1;
          else if (!s_hs)   state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Loading only happens on an s handshake, which in SPLIT implies the final
    // slice is being consumed, so a stalled beat is never overwritten.
    if (s_hs) begin
      idx_d   = '0;
      data_d  = s_axis_tdata;
      strb_d  = s_axis_tstrb;
      keep_d  = s_axis_tkeep;
      user_d  = s_axis_tuser;
      last_d  = s_axis_tlast;
      tid_d   = s_axis_tid;
      tdest_d = s_axis_tdest;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
      tid_q   <= '0;
      tdest_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      last_q  <= last_d;
      tid_q   <= tid_d;
      tdest_q <= tdest_d;
    end
  end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Randomised and directed bench for axis_width_downsizer (S=8, M=2) against a
// queue-based slice model of the byte stream.
module tb_axis_width_downsizer;

  localparam int S = 8;
  localparam int M = 2;
  localparam int R = S / M;

  typedef struct {
    logic [S*8-1:0] data;
    logic [S-1:0]   strb;
    logic [S-1:0]   keep;
    logic [S-1:0]   user;
    logic           last;
    logic           tid;
    logic           tdest;
  } in_beat_t;

  typedef struct {
    logic [M*8-1:0] data;
    logic [M-1:0]   strb;
    logic [M-1:0]   keep;
    logic [M-1:0]   user;
    logic           last;
    logic           tid;
    logic           tdest;
  } out_beat_t;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic [S*8-1:0] s_axis_tdata = '0;
  logic [S-1:0]   s_axis_tstrb = '0;
  logic [S-1:0]   s_axis_tkeep = '0;
  logic           s_axis_tlast = 1'b0;
  logic [0:0]     s_axis_tid = '0;
  logic [0:0]     s_axis_tdest = '0;
  logic [S-1:0]   s_axis_tuser = '0;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic [M*8-1:0] m_axis_tdata;
  logic [M-1:0]   m_axis_tstrb;
  logic [M-1:0]   m_axis_tkeep;
  logic [M-1:0]   m_axis_tuser;
  logic           m_axis_tlast;
  logic [0:0]     m_axis_tid;
  logic [0:0]     m_axis_tdest;

  axis_width_downsizer #(
    .S_TDATA_WIDTH(S), .M_TDATA_WIDTH(M), .TID_WIDTH(1), .TDEST_WIDTH(1),
    .TUSER_WIDTH_PER_BYTE(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;
  out_beat_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: a wide beat becomes RATIO slices, or for a tlast beat just
  // enough slices to cover its highest kept byte (at least one).
  task automatic model_push(input in_beat_t b);
    int h, n;
    out_beat_t e;
    h = -1;
    for (int i = 0; i < S; i++) if (b.keep[i]) h = i;
    if (!b.last)    n = R;
    else if (h < 0) n = 1;
    else            n = h / M + 1;
    for (int k = 0; k < n; k++) begin
      e.data  = b.data[k*M*8 +: M*8];
      e.strb  = b.strb[k*M +: M];
      e.keep  = b.keep[k*M +: M];
      e.user  = b.user[k*M +: M];
      e.last  = b.last && (k == n - 1);
      e.tid   = b.tid;
      e.tdest = b.tdest;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: handshakes and stall stability sampled on the falling edge.
  int          cyc = 0;
  int          s_hs_cyc = 0;
  bit          win_on = 0;
  int          win_cnt = 0, low_cnt = 0, first_cyc = 0, last_cyc = 0;
  bit          stall_prev = 0;
  logic [63:0] prev_bundle = '0;
  bit          rand_rdy = 0;

  always @(negedge aclk) begin
    out_beat_t e;
    in_beat_t  b;
    cyc++;
    if (aresetn) begin
      if (stall_prev) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_hold", 64'({m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tuser,
                               m_axis_tlast, m_axis_tid, m_axis_tdest}), prev_bundle);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(m_axis_tdata), 64'(e.data));
          chk("tstrb", 64'(m_axis_tstrb), 64'(e.strb));
          chk("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
          chk("tuser", 64'(m_axis_tuser), 64'(e.user));
          chk("tlast", 64'(m_axis_tlast), 64'(e.last));
          chk("tid",   64'(m_axis_tid),   64'(e.tid));
          chk("tdest", 64'(m_axis_tdest), 64'(e.tdest));
        end
        if (win_on) begin
          if (win_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          win_cnt++;
          if (!s_axis_tready) low_cnt++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        b.data = s_axis_tdata; b.strb = s_axis_tstrb; b.keep = s_axis_tkeep;
        b.user = s_axis_tuser; b.last = s_axis_tlast; b.tid = s_axis_tid[0];
        b.tdest = s_axis_tdest[0];
        model_push(b);
        s_hs_cyc = cyc;
      end
      stall_prev  = m_axis_tvalid && !m_axis_tready;
      prev_bundle = 64'({m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tuser,
                         m_axis_tlast, m_axis_tid, m_axis_tdest});
    end else begin
      stall_prev = 0;
    end
  end

  always @(posedge aclk) begin
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_beat(input logic [S*8-1:0] d, input logic [S-1:0] k,
                           input logic [S-1:0] st, input logic [S-1:0] u,
                           input logic l, input logic id, input logic de);
    int t;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tstrb = st;
    s_axis_tuser = u; s_axis_tlast = l; s_axis_tid = id; s_axis_tdest = de;
    t = 0;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      t++;
      if (t > 300) begin
        chk("s_tready_timeout", 64'(s_axis_tready), 64'd1);
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic s_idle();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic win_start();
    win_on = 1; win_cnt = 0; low_cnt = 0; first_cyc = 0; last_cyc = 0;
  endtask

  initial begin
    logic [S*8-1:0] d;
    logic [S-1:0]   k;

    // Reset state
    #2;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
    chk("rst_m_tkeep",  64'(m_axis_tkeep),  64'd0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    chk("rel_s_tready_pre_edge", 64'(s_axis_tready), 64'd0);
    @(posedge aclk);
    #1;
    chk("rel_s_tready_first_edge", 64'(s_axis_tready), 64'd1);

    // Single full tlast beat -> four slices, latency one cycle
    win_start();
    send_beat(64'h0807060504030201, 8'hFF, 8'hFF, 8'hA5, 1'b1, 1'b1, 1'b1);
    s_idle();
    wait_drain();
    chk("t1_count", 64'(win_cnt), 64'd4);
    chk("t1_latency", 64'(first_cyc - s_hs_cyc), 64'd1);
    win_on = 0;

    // Continuous 3-beat packet, no bubble
    win_start();
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b1);
    send_beat(64'h5555_6666_7777_8888, 8'hFF, 8'h3C, 8'hF0, 1'b0, 1'b0, 1'b1);
    send_beat(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 8'hFF, 8'h33, 1'b1, 1'b0, 1'b1);
    s_idle();
    wait_drain();
    chk("t2_count", 64'(win_cnt), 64'd12);
    chk("t2_span", 64'(last_cyc - first_cyc), 64'd11);
    chk("t2_s_tready_low", 64'(low_cnt), 64'd9);
    win_on = 0;

    // Partial last beat drops trailing null slices; next packet follows at once
    win_start();
    send_beat(64'hDEAD_BEEF_0123_4567, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    send_beat(64'hFFFF_FFFF_CAFE_F00D, 8'h0F, 8'h0F, 8'hFF, 1'b1, 1'b1, 1'b0);
    send_beat(64'h0102_0304_0506_0708, 8'hFF, 8'hFF, 8'h5A, 1'b1, 1'b0, 1'b0);
    s_idle();
    wait_drain();
    chk("t3_count", 64'(win_cnt), 64'd10);
    chk("t3_span", 64'(last_cyc - first_cyc), 64'd9);
    chk("t3_s_tready_low", 64'(low_cnt), 64'd7);
    win_on = 0;

    // tlast beat with no kept bytes -> exactly one null slice
    win_start();
    send_beat(64'h1234_5678_9ABC_DEF0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    s_idle();
    wait_drain();
    chk("t5_count", 64'(win_cnt), 64'd1);
    win_on = 0;

    // Randomised traffic with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       k = 8'hFF;
        1:       k = 8'hFF >> $urandom_range(0, 8);
        default: k = 8'($urandom_range(0, 255));
      endcase
      send_beat(d, k, k & 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        s_idle();
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
    end
    s_idle();
    wait_drain();
    rand_rdy = 0;
    @(posedge aclk);
    #1;

    // Reset after the first slice of a beat discards the rest
    send_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    s_idle();
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("mid_rst_m_tdata",  64'(m_axis_tdata),  64'd0);
    chk("mid_rst_m_tlast",  64'(m_axis_tlast),  64'd0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("mid_rel_s_tready", 64'(s_axis_tready), 64'd1);
    win_start();
    send_beat(64'h4444_3333_2222_1111, 8'hFF, 8'hFF, 8'hC3, 1'b1, 1'b1, 1'b0);
    s_idle();
    wait_drain();
    chk("t6_count", 64'(win_cnt), 64'd4);
    win_on = 0;

    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_chk);
    $fatal(1, "timeout");
  end

endmodule
